// File: rtl/alu_sweep_sequencer.sv
// alu_sweep_sequencer: walks an external ALU through every select code enabled
// in a latched mask. Each code is held for SETTLE_CYC cycles, then the 16-bit
// result is captured into an 8-entry buffer, flagged valid and added to a
// running modulo-2^16 sum. Codes run in ascending order; unmasked codes are skipped.
module alu_sweep_sequencer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [7:0]  op_mask,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_s,
  input  logic [7:0]  alu_yh,
  input  logic [7:0]  alu_yl,
  output logic        busy,
  output logic        done,
  output logic [7:0]  res_valid,
  output logic [15:0] sum,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Counter reload: SETTLE is left when the counter reaches zero, so loading
  // SETTLE_CYC-1 gives exactly SETTLE_CYC cycles in SETTLE.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_s_q, alu_s_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  res_valid_q, res_valid_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] buf_q [8];
  logic [15:0] buf_d [8];
  logic [15:0] alu_y;
  logic [3:0]  nxt;

  assign alu_y = {alu_yh, alu_yl};

  // Lowest set mask bit at or above 'from'; 8 means none remain.
  function automatic logic [3:0] next_code(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] code;
    code = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k] && (4'(k) >= from)) code = 4'(k);
    end
    return code;
  endfunction

  // Next-state and next-output logic for the sweep FSM, buffer and read port.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = res_valid_q;
    sum_d       = sum_q;
    buf_d       = buf_q;
    nxt         = 4'd8;
    // Registered read sees the buffer before any write on the same edge.
    rd_data_d   = buf_q[rd_addr];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alu_a_d     = op_a;
          alu_b_d     = op_b;
          mask_d      = op_mask;
          res_valid_d = '0;
          sum_d       = '0;
          nxt         = next_code(op_mask, 4'd0);
          if (nxt[3]) begin
            // Empty mask: straight to DONE without ever raising busy.
            alu_s_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            alu_s_d = nxt[2:0];
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        buf_d[alu_s_q]       = alu_y;
        res_valid_d[alu_s_q] = 1'b1;
        sum_d                = sum_q + alu_y;
        nxt                  = next_code(mask_q, {1'b0, alu_s_q} + 4'd1);
        if (nxt[3]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          alu_s_d = nxt[2:0];
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= '0;
      sum_q       <= '0;
      rd_data_q   <= '0;
      // NOTE: the result buffer must read back zero after reset, so it is built from resettable flops rather than a RAM.
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      sum_q       <= sum_d;
      rd_data_q   <= rd_data_d;
      for (int i = 0; i < 8; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign sum       = sum_q;
  assign rd_data   = rd_data_q;

endmodule
